clint_mmio: RTL and testbench

CLINT_MMIO -- requirements
Module: clint_mmio

---
 rtl/clint_mmio_pkg.sv | 34 +++
 rtl/clint_timer.sv | 67 ++++++
 rtl/clint_mmio.sv | 102 ++++++++++
 tb/tb_clint_mmio.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_mmio_pkg.sv
// clint_mmio_pkg: shared definitions for the CLINT memory-mapped block.
//   - Word offsets of the decoded registers inside the 64 KiB window.
//   - Bus FSM state encoding.
//   - merge_bytes(): byte-lane merge used by every writable register.
package clint_mmio_pkg;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_t;

    // Bytes whose enable bit is set take new_word, the rest keep old_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  byte_en
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler, 64-bit mtime counter, mtimecmp register and the
// timer interrupt compare.
//   clk, reset (async, active-low)
//   wr_mtime_lo/hi, wr_cmp_lo/hi : one-cycle write strobes from the bus decode
//   wdata, byte_select           : write data and byte-lane enables
//   mtime, mtimecmp              : current register values (for readback)
//   mtimer_irq                   : registered (mtime >= mtimecmp)
module clint_timer
    import clint_mmio_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_mtime_lo,
    input  logic        wr_mtime_hi,
    input  logic        wr_cmp_lo,
    input  logic        wr_cmp_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_select,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtimer_irq
);

    logic [15:0] presc_reg, presc_next;
    logic [63:0] mtime_reg, mtime_next, mtime_inc;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic        mtimer_irq_reg;
    logic        tick;

    assign tick      = (presc_reg == 16'(TICK_DIV - 1));
    assign presc_next = tick ? 16'd0 : presc_reg + 16'd1;

    // The full 64-bit increment is formed first so a carry out of the low
    // half reaches the high half even when the high half is partly written.
    assign mtime_inc = mtime_reg + {63'd0, tick};

    always_comb begin
        mtime_next    = mtime_inc;
        mtimecmp_next = mtimecmp_reg;
        if (wr_mtime_lo) mtime_next[31:0]     = merge_bytes(mtime_inc[31:0],     wdata, byte_select);
        if (wr_mtime_hi) mtime_next[63:32]    = merge_bytes(mtime_inc[63:32],    wdata, byte_select);
        if (wr_cmp_lo)   mtimecmp_next[31:0]  = merge_bytes(mtimecmp_reg[31:0],  wdata, byte_select);
        if (wr_cmp_hi)   mtimecmp_next[63:32] = merge_bytes(mtimecmp_reg[63:32], wdata, byte_select);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg      <= 16'd0;
            mtime_reg      <= 64'd0;
            mtimecmp_reg   <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtimer_irq_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            mtime_reg      <= mtime_next;
            mtimecmp_reg   <= mtimecmp_next;
            // Compare uses the values before this edge's updates.
            mtimer_irq_reg <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign mtime      = mtime_reg;
    assign mtimecmp   = mtimecmp_reg;
    assign mtimer_irq = mtimer_irq_reg;

endmodule

// File: rtl/clint_mmio.sv
// clint_mmio: RISC-V style core-local interruptor on a simple CPU data port.
//   clk, reset (async, active-low)
//   addr, wdata, ren, wen, byte_select : CPU data-port request
//   rdata      : registered read data, valid while in RESP
//   ready      : low only while a hit read is waiting in IDLE
//   msw_irq    : machine software interrupt (msip bit 0)
//   mtimer_irq : machine timer interrupt
// Reads take one stall cycle (IDLE -> RESP); writes complete with no stall.
module clint_mmio
    import clint_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_select,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        msw_irq,
    output logic        mtimer_irq
);

    bus_state_t  state_reg;
    logic [31:0] rdata_reg;
    logic        msip_reg;
    logic [31:0] rd_word;
    logic [15:0] offset;
    logic        hit, idle, rd_accept, wr_accept;
    logic [63:0] mtime, mtimecmp;
    logic [1:0]  unused_addr_lsbs;

    // Byte offset bits [1:0] do not select anything.
    assign unused_addr_lsbs = addr[1:0];

    assign hit       = (addr[31:16] == BASE_ADDR[31:16]);
    assign offset    = {addr[15:2], 2'b00};
    assign idle      = (state_reg == ST_IDLE);
    assign wr_accept = idle & hit & wen;
    // Gating with reset keeps ready high while reset is held low.
    assign rd_accept = reset & idle & hit & ren;
    assign ready     = ~rd_accept;

    always_comb begin
        rd_word = 32'd0;
        unique case (offset)
            OFF_MSIP:        rd_word = {31'd0, msip_reg};
            OFF_MTIMECMP_LO: rd_word = mtimecmp[31:0];
            OFF_MTIMECMP_HI: rd_word = mtimecmp[63:32];
            OFF_MTIME_LO:    rd_word = mtime[31:0];
            OFF_MTIME_HI:    rd_word = mtime[63:32];
            default:         rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            rdata_reg <= 32'd0;
            msip_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (hit && ren) begin
                        state_reg <= ST_RESP;
                        rdata_reg <= rd_word;
                    end
                    if (wr_accept && offset == OFF_MSIP && byte_select[0]) begin
                        msip_reg <= wdata[0];
                    end
                end
                // Requests still presented in RESP are the one just served.
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .wr_mtime_lo (wr_accept && offset == OFF_MTIME_LO),
        .wr_mtime_hi (wr_accept && offset == OFF_MTIME_HI),
        .wr_cmp_lo   (wr_accept && offset == OFF_MTIMECMP_LO),
        .wr_cmp_hi   (wr_accept && offset == OFF_MTIMECMP_HI),
        .wdata       (wdata),
        .byte_select (byte_select),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .mtimer_irq  (mtimer_irq)
    );

    assign rdata   = rdata_reg;
    assign msw_irq = msip_reg;

endmodule

// File: tb/tb_clint_mmio.sv
// Directed testbench for clint_mmio (TICK_DIV = 1, so mtime advances on
// every clock edge). Inputs change on the falling edge; outputs are checked
// on the falling edge or shortly after a change.
module tb_clint_mmio;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic [3:0]  byte_select;
    logic [31:0] rdata;
    logic        ready;
    logic        msw_irq;
    logic        mtimer_irq;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    clint_mmio #(
        .BASE_ADDR (BASE),
        .TICK_DIV  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .ren         (ren),
        .wen         (wen),
        .byte_select (byte_select),
        .rdata       (rdata),
        .ready       (ready),
        .msw_irq     (msw_irq),
        .mtimer_irq  (mtimer_irq)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // One write: presented from a falling edge, taken at the next rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byte_select = be; wen = 1'b1;
        #1 check("wr_no_stall", ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0; byte_select = 4'd0;
    endtask

    // One read: capture edge then RESP edge; returns on a falling edge in IDLE.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; ren = 1'b1;
        #1 check("rd_stall", ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rd_ready", ready, 1'b1);
        d = rdata;
        ren = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;

        reset = 1'b0; addr = 32'd0; wdata = 32'd0; ren = 1'b0; wen = 1'b0; byte_select = 4'd0;
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_msw", msw_irq, 1'b0);
        check("rst_mtimer", mtimer_irq, 1'b0);
        addr = BASE + 32'h4000; ren = 1'b1;
        #1 check("rst_ready_with_ren", ready, 1'b1);
        ren = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);                 // mtime 0 -> 1
        @(negedge clk);
        do_read(BASE + 32'hBFF8, d);    // captures mtime = 1
        check("mtime_after_reset", d, 32'd1);

        // Read with ren held through RESP: not re-accepted, then a new request.
        addr = BASE + 32'h4000; ren = 1'b1;
        #1 check("cmp_lo_stall", ready, 1'b0);
        @(posedge clk); @(negedge clk);
        check("cmp_lo_ready", ready, 1'b1);
        check("cmp_lo_reset_val", rdata, 32'hFFFF_FFFF);
        @(posedge clk); @(negedge clk);
        check("next_req_stall", ready, 1'b0);
        check("rdata_held_idle", rdata, 32'hFFFF_FFFF);
        @(posedge clk); @(negedge clk);
        check("next_req_ready", ready, 1'b1);
        ren = 1'b0;
        @(posedge clk); @(negedge clk);
        do_read(BASE + 32'h4004, d);
        check("cmp_hi_reset_val", d, 32'hFFFF_FFFF);

        // Software interrupt.
        do_write(BASE, 32'd1, 4'b0001);
        check("msw_set", msw_irq, 1'b1);
        do_read(BASE, d);
        check("msip_read_1", d, 32'd1);
        do_write(BASE, 32'd0, 4'b0001);
        check("msw_clear", msw_irq, 1'b0);
        do_write(BASE, 32'hFFFF_FFFF, 4'b0010);
        check("msip_lane_off", msw_irq, 1'b0);
        do_write(BASE, 32'hFFFF_FFFF, 4'b1111);
        check("msw_set_all", msw_irq, 1'b1);
        do_read(BASE, d);
        check("msip_upper_zero", d, 32'd1);
        do_write(BASE, 32'd0, 4'b1111);
        check("msw_clear_all", msw_irq, 1'b0);

        // Byte-lane merge on mtimecmp.
        do_write(BASE + 32'h4000, 32'hAABB_CCDD, 4'b0010);
        do_read(BASE + 32'h4000, d);
        check("cmp_lo_byte_merge", d, 32'hFFFF_CCFF);
        do_write(BASE + 32'h4000, 32'hFFFF_FFFF, 4'b1111);

        // Non-hit accesses: no stall, rdata held, no state change.
        addr = 32'h0300_0000; ren = 1'b1;
        #1 check("nohit_rd_ready", ready, 1'b1);
        @(posedge clk); @(negedge clk);
        check("nohit_rdata_held", rdata, 32'hFFFF_CCFF);
        check("nohit_ready_after", ready, 1'b1);
        ren = 1'b0;
        do_write(32'h0300_0000, 32'd1, 4'b1111);
        check("nohit_wr_msw", msw_irq, 1'b0);
        do_read(BASE + 32'h0100, d);
        check("unmapped_read", d, 32'd0);
        do_read(BASE + 32'h4008, d);
        check("unmapped_4008", d, 32'd0);
        do_read(BASE + 32'h4002, d);
        check("addr_lsb_ignored", d, 32'hFFFF_FFFF);

        // mtime carry from low into high half.
        do_write(BASE + 32'hBFFC, 32'd0, 4'b1111);           // edge A
        do_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'b1111);   // edge B
        do_read(BASE + 32'hBFF8, d);                         // capture B+1
        check("mtime_lo_all_ones", d, 32'hFFFF_FFFF);
        do_read(BASE + 32'hBFFC, d);                         // capture B+3
        check("mtime_hi_carry", d, 32'd1);
        do_read(BASE + 32'hBFF8, d);                         // capture B+5
        check("mtime_lo_wrapped", d, 32'd3);
        check("mtimer_low_big_cmp", mtimer_irq, 1'b0);

        // Write high half on a tick edge; low half keeps counting.
        do_write(BASE + 32'hBFFC, 32'h1234_5678, 4'b1111);   // edge C, lo 5 -> 6
        do_read(BASE + 32'hBFFC, d);
        check("mtime_hi_written", d, 32'h1234_5678);
        do_read(BASE + 32'hBFF8, d);                         // capture C+3
        check("mtime_lo_counting", d, 32'd8);
        do_write(BASE + 32'hBFF8, 32'hAA00_0000, 4'b1000);   // edge D, lo 10 -> 11 merged
        do_read(BASE + 32'hBFF8, d);
        check("mtime_lo_partial_tick", d, 32'hAA00_000B);

        // Reset pulsed in the middle of a read.
        addr = BASE + 32'h4004; ren = 1'b1;
        @(posedge clk);
        #2;
        check("mid_read_ready", ready, 1'b1);
        check("mid_read_rdata", rdata, 32'hFFFF_FFFF);
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_rdata", rdata, 32'd0);
        check("abort_mtimer", mtimer_irq, 1'b0);
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        reset = 1'b1;                                        // release at R
        ren = 1'b1;
        #1 check("post_abort_idle", ready, 1'b0);
        check("post_abort_rdata", rdata, 32'd0);
        ren = 1'b0;

        // Timer compare: mtime == k after edge R+k.
        do_write(BASE + 32'h4004, 32'd0, 4'b1111);           // R+1
        do_write(BASE + 32'h4000, 32'd5, 4'b1111);           // R+2
        for (int k = 3; k <= 9; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("mtimer_edge_%0d", k), mtimer_irq, (k >= 6) ? 1'b1 : 1'b0);
        end
        do_write(BASE + 32'h4004, 32'd1, 4'b1111);
        check("mtimer_hold_on_cmp_write", mtimer_irq, 1'b1);
        @(posedge clk); @(negedge clk);
        check("mtimer_cleared", mtimer_irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
